alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Execute-stage front end for the 32-bit MIPS-style ALU; sits directly upstream of it.
- Accepts decoded R-type/LUI instructions over a valid/ready handshake, selects operands, and maps funct to the 6-bit aluc code.
- Drives the ALU from a registered issue stage, then captures the ALU's combinational result and flags into a registered output stage.
- Two-entry pipeline; full throughput of 1 instruction per clock.

Parameters:
- DW, 32, datapath width (only 32 is supported).
- RW, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept an instruction.
- in_funct  in  6  R-type funct field.
- in_is_lui  in  1  instruction is LUI; overrides in_funct.
- in_shamt  in  5  shift amount.
- in_imm  in  16  immediate (LUI).
- in_rs_data  in  32  rs operand.
- in_rt_data  in  32  rt operand.
- in_rs_idx, in_rt_idx, in_rd_idx  in  5 each  register indices, used for forwarding.
- alu_a, alu_b  out  32  registered ALU operands.
- alu_aluc  out  6  registered ALU op code.
- alu_r  in  32  ALU result.
- alu_zero, alu_carry, alu_negative, alu_overflow, alu_flag  in  1 each  ALU flags.
- out_valid  in-direction out, 1  result available.
- out_ready  in  1  consumer accepts the result.
- out_r  out  32  result.
- out_rd  out  5  destination index.
- out_flags  out  5  {zero,carry,negative,overflow,flag}.
- out_ovf_trap  out  1  signed overflow on ADD/SUB.
- out_illegal  out  1  unsupported funct.

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid=0, s2_valid=0.
  - alu_a=0, alu_b=0, alu_aluc=0.
  - out_r=0, out_rd=0, out_flags=0, out_ovf_trap=0, out_illegal=0.
  - in_ready=1 once reset releases.
  - Reset mid-operation discards all in-flight instructions; no partial output.
- Decode (combinational on inputs, registered into stage 1):
  - in_is_lui=1: aluc=001111, a=0, b={16'h0,in_imm}.
  - SLL/SRL/SRA (000000/000010/000011): a={27'b0,in_shamt}, b=in_rt_data.
  - ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLLV, SRLV, SRAV: a=in_rs_data, b=in_rt_data, aluc=funct.
  - Any other funct, including JR 001000: illegal=1, aluc=100001, a=b=0.
- Handshake and advance:
  - s1_adv = s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | s1_adv.
  - Accept on in_valid & in_ready at a clock edge.
  - On s1_adv, stage 2 captures: alu_r, the flags, s1 rd, s1 illegal.
  - out_ovf_trap = alu_overflow & (aluc==ADD | aluc==SUB).
  - Illegal instructions force out_r=0, out_flags=0, out_ovf_trap=0.
  - s2_valid clears on out_ready when no new capture occurs.
  - Simultaneous accept-in, advance and drain in one cycle is legal.
- Latency: accepted at edge N → alu_* valid after N → out_valid after edge N+1 (2 cycles).
- Backpressure:
  - out_ready=0 holds both stages, with alu_* stable.
  - in_ready=0 once both stages are full.
  - No instruction is dropped, duplicated or reordered.
- out_valid=1 holds out_* stable until the handshake completes.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: operand forwarding at accept, for a register rs or rt (not shamt/LUI) whose index is nonzero and matches a destination:
  - First priority: s1 rd with s1_valid & ~s1_illegal → use alu_r.
  - Second priority: s2 rd with s2_valid & ~s2_illegal → use out_r.
- Undefined: the idx ports are ignored; operands are taken from in_rs_data/in_rt_data unchanged.

Test Plan:
- ADD rs=0x1c, rt=0x21 → alu_a=0x1c, alu_b=0x21, aluc=100000; out_r=0x3d two cycles after accept; out_ovf_trap=0.
- SLL shamt=4, rt=0x21 → alu_a=0x4, alu_b=0x21, aluc=000000; out_r=0x210. LUI imm=0x1234 → alu_b=0x00001234; out_r=0x12340000.
- ADD 0x7fffffff+0x1 → out_ovf_trap=1, out_r=0x80000000. Same operands with ADDU → out_ovf_trap=0.
- funct=001000 (JR) → out_illegal=1, out_r=0, out_flags=0. Next instruction (e.g. AND 0xff,0x0f → out_r=0x0f) is unaffected.
- out_ready=0 for 4 cycles, 3 back-to-back inputs:
  - in_ready falls after 2 accepts.
  - On release, results appear in order, 1/cycle.
  - Assert rst_n low mid-stream → out_valid=0 immediately; all outputs zero.
- With ALU_ISSUE_FWD_EN, back-to-back instructions:
  - ADDU rd=5 (0x10+0x20), then OR rs_idx=5 (stale rs_data=0), rt=0x1 → out_r=0x31.
  - rd=0 is never forwarded.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-entry issue/result pipeline in front of a combinational
// 32-bit MIPS-style ALU. Stage 1 (alu_a, alu_b, alu_aluc) drives the ALU. Stage 2
// (out_*) captures the ALU result and flags. Throughput is one instruction per clock.
// Optional feature: define ALU_ISSUE_FWD_EN to forward in-flight results into the
// rs/rt operands at accept. Without it the register-index ports are ignored.
module alu_issue_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_funct,
    input  logic          in_is_lui,
    input  logic [4:0]    in_shamt,
    input  logic [15:0]   in_imm,
    input  logic [DW-1:0] in_rs_data,
    input  logic [DW-1:0] in_rt_data,
    input  logic [RW-1:0] in_rs_idx,
    input  logic [RW-1:0] in_rt_idx,
    input  logic [RW-1:0] in_rd_idx,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [5:0]    alu_aluc,
    input  logic [DW-1:0] alu_r,
    input  logic          alu_zero,
    input  logic          alu_carry,
    input  logic          alu_negative,
    input  logic          alu_overflow,
    input  logic          alu_flag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_r,
    output logic [RW-1:0] out_rd,
    output logic [4:0]    out_flags,
    output logic          out_ovf_trap,
    output logic          out_illegal
);

    // funct / aluc codes understood by the downstream ALU
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] ALUC_LUI     = 6'b001111;
    // Illegal instructions issue a harmless ADDU 0+0; stage 2 masks the result anyway.
    localparam logic [5:0] ALUC_ILLEGAL = 6'b100001;

    logic          s1_valid;
    logic          s1_illegal;
    logic [RW-1:0] s1_rd;
    logic          s1_adv;
    logic          accept;

    logic [DW-1:0] rs_op;
    logic [DW-1:0] rt_op;
    logic [DW-1:0] dec_a;
    logic [DW-1:0] dec_b;
    logic [5:0]    dec_aluc;
    logic          dec_illegal;

    // Stage 1 moves on when stage 2 is empty or is draining this cycle.
    assign s1_adv   = s1_valid & (~s2_empty_n() | out_ready);
    assign in_ready = ~s1_valid | s1_adv;
    assign accept   = in_valid & in_ready;

    function automatic logic s2_empty_n();
        return out_valid;
    endfunction

`ifdef ALU_ISSUE_FWD_EN
    // Operand forwarding: the youngest legal in-flight producer wins. Register 0 is never forwarded.
    always_comb begin
        rs_op = in_rs_data;
        rt_op = in_rt_data;
        if (in_rs_idx != '0 && s1_valid && !s1_illegal && in_rs_idx == s1_rd) begin
            rs_op = alu_r;
        end else if (in_rs_idx != '0 && out_valid && !out_illegal && in_rs_idx == out_rd) begin
            rs_op = out_r;
        end
        if (in_rt_idx != '0 && s1_valid && !s1_illegal && in_rt_idx == s1_rd) begin
            rt_op = alu_r;
        end else if (in_rt_idx != '0 && out_valid && !out_illegal && in_rt_idx == out_rd) begin
            rt_op = out_r;
        end
    end
`else
    // Without forwarding the source indices carry no meaning for this block.
    logic unused_idx;
    assign unused_idx = ^{in_rs_idx, in_rt_idx};
    assign rs_op      = in_rs_data;
    assign rt_op      = in_rt_data;
`endif

    // Decode: choose operands and the ALU op code from funct / LUI.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        dec_a       = '0;
        dec_b       = '0;
        dec_aluc    = ALUC_ILLEGAL;
        dec_illegal = 1'b0;
        if (in_is_lui) begin
            dec_aluc = ALUC_LUI;
            dec_b    = {{(DW-16){1'b0}}, in_imm};
        end else begin
            case (in_funct)
                F_SLL, F_SRL, F_SRA: begin
                    dec_a    = {{(DW-5){1'b0}}, in_shamt};
                    dec_b    = rt_op;
                    dec_aluc = in_funct;
                end
                F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                F_SLT, F_SLTU, F_SLLV, F_SRLV, F_SRAV: begin
                    dec_a    = rs_op;
                    dec_b    = rt_op;
                    dec_aluc = in_funct;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    // Stage 1 (issue): load on accept, empty when it advances with nothing behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_illegal <= 1'b0;
            s1_rd      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_aluc   <= '0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            if (accept) begin
                s1_valid   <= 1'b1;
                s1_illegal <= dec_illegal;
                s1_rd      <= in_rd_idx;
                alu_a      <= dec_a;
                alu_b      <= dec_b;
                alu_aluc   <= dec_aluc;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 (result): capture ALU outputs on advance, otherwise drain on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_r        <= '0;
            out_rd       <= '0;
            out_flags    <= '0;
            out_ovf_trap <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (s1_adv) begin
            out_valid    <= 1'b1;
            out_rd       <= s1_rd;
            out_illegal  <= s1_illegal;
            out_r        <= s1_illegal ? '0 : alu_r;
            out_flags    <= s1_illegal ? 5'b0
                          : {alu_zero, alu_carry, alu_negative, alu_overflow, alu_flag};
            out_ovf_trap <= ~s1_illegal & alu_overflow
                          & ((alu_aluc == F_ADD) | (alu_aluc == F_SUB));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
